// File: rtl/pc_gen_pkg.sv
// Shared defaults and types for the program-counter generator slice.
package pc_gen_pkg;

    localparam int          DEF_XLEN       = 32;
    localparam logic [31:0] DEF_RESET_VEC  = 32'h8000_0000;
    localparam int          DEF_INST_BYTES = 4;
    localparam int          DEF_BOOT_DELAY = 1;

    typedef logic [DEF_XLEN-1:0] pc_t;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch request handshake between the PC generator (master) and the IFU (slave).
interface pc_gen_if
    import pc_gen_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
);
    logic            fetch_valid;
    logic [XLEN-1:0] fetch_pc;
    logic            fetch_epoch;
    logic            fetch_ready;

    modport master (
        output fetch_valid,
        output fetch_pc,
        output fetch_epoch,
        input  fetch_ready
    );

    modport slave (
        input  fetch_valid,
        input  fetch_pc,
        input  fetch_epoch,
        output fetch_ready
    );
endinterface

// File: rtl/pc_gen_redirect_buf.sv
// Redirect/trap target selection, alignment, misalign flag and the pending-target
// buffer that parks a target while the current fetch request is held.
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int INST_BYTES = DEF_INST_BYTES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            boot_done,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            hold_next,
    input  logic            fire,
    output logic            take_now,
    output logic [XLEN-1:0] tgt_pc,
    output logic            pend_load,
    output logic [XLEN-1:0] pend_pc,
    output logic            misalign
);

    localparam int              ALIGN_W    = $clog2(INST_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << ALIGN_W;

    logic [XLEN-1:0] raw_tgt_s;
    logic            tgt_v_s;
    logic            buf_write_s;
    logic            accept_s;
    logic            pend_v_r;
    logic            pend_trap_r;
    logic [XLEN-1:0] pend_pc_r;
    logic            misalign_r;

    // Target priority, alignment and accept/buffer decisions.
    always_comb begin
        raw_tgt_s = redirect_pc;
        if (trap_valid) begin
            raw_tgt_s = trap_pc;
        end else begin
            raw_tgt_s = redirect_pc;
        end
        tgt_v_s     = boot_done & (trap_valid | redirect_valid);
        take_now    = tgt_v_s & ~hold_next;
        // A plain redirect may not displace a trap already waiting in the buffer.
        buf_write_s = tgt_v_s & hold_next & (trap_valid | ~pend_v_r | ~pend_trap_r);
        accept_s    = take_now | buf_write_s;
        tgt_pc      = raw_tgt_s & ALIGN_MASK;
        pend_load   = fire & pend_v_r;
    end

    // Pending-target buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_v_r    <= 1'b0;
            pend_trap_r <= 1'b0;
            pend_pc_r   <= {XLEN{1'b0}};
        end else if (take_now) begin
            pend_v_r    <= 1'b0;
            pend_trap_r <= 1'b0;
        end else if (buf_write_s) begin
            pend_v_r    <= 1'b1;
            pend_trap_r <= trap_valid;
            pend_pc_r   <= tgt_pc;
        end else if (pend_load) begin
            pend_v_r    <= 1'b0;
            pend_trap_r <= 1'b0;
        end else begin
            pend_v_r    <= pend_v_r;
            pend_trap_r <= pend_trap_r;
        end
    end

    // One-cycle flag for an accepted target with nonzero low bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= accept_s & (|(raw_tgt_s & ~ALIGN_MASK));
        end
    end

    assign pend_pc  = pend_pc_r;
    assign misalign = misalign_r;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: boot delay, held fetch requests, prioritised
// redirects with a pending buffer, and an epoch tag that flips on every redirect.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN       = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEF_RESET_VEC),
    parameter int              INST_BYTES = DEF_INST_BYTES,
    parameter int              BOOT_DELAY = DEF_BOOT_DELAY
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    pc_gen_if.master        fetch,
    output logic            boot_done,
    output logic            misalign
);

    localparam int CNT_W = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY + 1) : 1;

    logic [CNT_W-1:0] boot_cnt_r;
    logic             boot_done_r;
    logic             hold_r;
    logic [XLEN-1:0]  pc_r;
    logic             epoch_r;

    logic             fetch_valid_s;
    logic             fire_s;
    logic             hold_next_s;
    logic             take_now_s;
    logic [XLEN-1:0]  tgt_pc_s;
    logic             pend_load_s;
    logic [XLEN-1:0]  pend_pc_s;
    logic [XLEN-1:0]  pc_next_s;
    logic             epoch_next_s;

    // Handshake: a held request stays valid regardless of stall.
    always_comb begin
        fetch_valid_s = boot_done_r & (hold_r | ~stall);
        fire_s        = fetch_valid_s & fetch.fetch_ready;
        hold_next_s   = fetch_valid_s & ~fetch.fetch_ready;
    end

    pc_redirect_buf #(
        .XLEN       (XLEN),
        .INST_BYTES (INST_BYTES)
    ) u_redirect_buf (
        .clk            (clk),
        .rst_n          (rst_n),
        .boot_done      (boot_done_r),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .hold_next      (hold_next_s),
        .fire           (fire_s),
        .take_now       (take_now_s),
        .tgt_pc         (tgt_pc_s),
        .pend_load      (pend_load_s),
        .pend_pc        (pend_pc_s),
        .misalign       (misalign)
    );

    // Next-PC mux; the epoch flips exactly when a target is loaded.
    always_comb begin
        pc_next_s    = pc_r;
        epoch_next_s = epoch_r;
        if (take_now_s) begin
            pc_next_s    = tgt_pc_s;
            epoch_next_s = ~epoch_r;
        end else if (pend_load_s) begin
            pc_next_s    = pend_pc_s;
            epoch_next_s = ~epoch_r;
        end else if (fire_s) begin
            pc_next_s    = pc_r + XLEN'(INST_BYTES);
        end else begin
            pc_next_s    = pc_r;
        end
    end

    // Boot delay counter; boot_done is sticky until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            boot_cnt_r  <= {CNT_W{1'b0}};
            boot_done_r <= 1'b0;
        end else if (!boot_done_r) begin
            boot_cnt_r  <= boot_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            boot_done_r <= (boot_cnt_r == CNT_W'(BOOT_DELAY - 1));
        end else begin
            boot_cnt_r  <= boot_cnt_r;
            boot_done_r <= 1'b1;
        end
    end

    // PC, epoch and hold state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r    <= RESET_VEC;
            epoch_r <= 1'b0;
            hold_r  <= 1'b0;
        end else begin
            pc_r    <= pc_next_s;
            epoch_r <= epoch_next_s;
            hold_r  <= hold_next_s;
        end
    end

    assign fetch.fetch_valid = fetch_valid_s;
    assign fetch.fetch_pc    = pc_r;
    assign fetch.fetch_epoch = epoch_r;
    assign boot_done         = boot_done_r;

endmodule
